// File: rtl/mux_rr_n.sv
// N-channel registered multiplexer with valid/ready handshaking.
// Channel choice is either an external select or round-robin among valid inputs.
module mux_rr_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_chan_r;
  logic                out_valid_r;

  logic [CHANNELS-1:0] grant_s;
  logic [SEL_W-1:0]    gidx_s;
  logic                hit_s;
  logic                load_s;
  logic                xfer_s;
  logic [SEL_W-1:0]    nxt_ptr_s;

  assign load_s    = !out_valid_r || out_ready;
  assign xfer_s    = hit_s && load_s;
  assign nxt_ptr_s = (int'(gidx_s) == CHANNELS - 1) ? '0 : gidx_s + SEL_W'(1);

  // Grant selection: fixed select, or first valid channel scanning upward from ptr.
  always_comb begin : arb
    int idx;
    idx     = 0;
    grant_s = '0;
    gidx_s  = '0;
    hit_s   = 1'b0;
    if (!mode) begin
      // An out-of-range select matches no channel and so grants nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i) begin
          grant_s[i] = 1'b1;
          gidx_s     = SEL_W'(i);
          hit_s      = in_valid[i];
        end else begin
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = (int'(ptr_r) + k) % CHANNELS;
        if (!hit_s && in_valid[idx]) begin
          grant_s[idx] = 1'b1;
          gidx_s       = SEL_W'(idx);
          hit_s        = 1'b1;
        end else begin
        end
      end
    end
  end

  // Ready goes to the granted channel when the output stage can load, never in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n) begin
      in_ready = grant_s & {CHANNELS{load_s}};
    end else begin
      in_ready = '0;
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
      ptr_r       <= '0;
    end else if (load_s) begin
      if (xfer_s) begin
        out_data_r  <= in_data[gidx_s*WIDTH +: WIDTH];
        out_chan_r  <= gidx_s;
        out_valid_r <= 1'b1;
        if (mode) begin
          ptr_r <= nxt_ptr_s;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: default, 5-channel and legacy 2:1 single-bit instances.
module tb_mux_rr_n;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  // default instance: WIDTH=16, CHANNELS=4
  logic        d4_mode, d4_out_valid, d4_out_ready;
  logic [1:0]  d4_sel, d4_out_chan;
  logic [63:0] d4_in_data;
  logic [3:0]  d4_in_valid, d4_in_ready;
  logic [15:0] d4_out_data;

  // non-power-of-two instance: WIDTH=8, CHANNELS=5
  logic        d5_mode, d5_out_valid, d5_out_ready;
  logic [2:0]  d5_sel, d5_out_chan;
  logic [39:0] d5_in_data;
  logic [4:0]  d5_in_valid, d5_in_ready;
  logic [7:0]  d5_out_data;

  // legacy instance: WIDTH=1, CHANNELS=2
  logic        d2_mode, d2_out_valid, d2_out_ready, d2_sel, d2_out_chan, d2_out_data;
  logic [1:0]  d2_in_data, d2_in_valid, d2_in_ready;

  mux_rr_n dut4 (
    .clk(clk), .rst_n(rst_n), .mode(d4_mode), .sel(d4_sel),
    .in_data(d4_in_data), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .out_data(d4_out_data), .out_chan(d4_out_chan), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready)
  );

  mux_rr_n #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(d5_mode), .sel(d5_sel),
    .in_data(d5_in_data), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
    .out_data(d5_out_data), .out_chan(d5_out_chan), .out_valid(d5_out_valid),
    .out_ready(d5_out_ready)
  );

  mux_rr_n #(.WIDTH(1), .CHANNELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(d2_mode), .sel(d2_sel),
    .in_data(d2_in_data), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .out_data(d2_out_data), .out_chan(d2_out_chan), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic exp;
  } leg_t;

  leg_t tbl[8];

  // reference model state for the default instance
  int          m_ptr;
  logic        m_val;
  logic [15:0] m_data;
  int          m_chan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One random cycle on the default instance, checked against the model.
  task automatic rand_cycle();
    int         g;
    int         c;
    logic       ld;
    logic [3:0] exp_rdy;
    @(negedge clk);
    check("rnd_valid", 32'(d4_out_valid), 32'(m_val));
    check("rnd_data", 32'(d4_out_data), 32'(m_data));
    check("rnd_chan", 32'(d4_out_chan), 32'(m_chan));
    d4_mode      = ($urandom_range(0, 3) != 0);
    d4_sel       = 2'($urandom_range(0, 3));
    d4_in_valid  = 4'($urandom);
    d4_in_data   = {$urandom, $urandom};
    d4_out_ready = ($urandom_range(0, 3) != 0);
    #1;
    ld = !m_val || d4_out_ready;
    g  = -1;
    if (!d4_mode) begin
      g = int'(d4_sel);
    end else begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && d4_in_valid[c]) g = c;
      end
    end
    exp_rdy = (g >= 0 && ld) ? 4'(1 << g) : 4'b0000;
    check("rnd_ready", 32'(d4_in_ready), 32'(exp_rdy));
    if (ld) begin
      if (g >= 0 && d4_in_valid[g]) begin
        m_data = d4_in_data[g*16 +: 16];
        m_chan = g;
        m_val  = 1'b1;
        if (d4_mode) m_ptr = (g + 1) % 4;
      end else begin
        m_val = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    rst_n        = 1'b0;
    d4_mode      = 1'b0; d4_sel = 2'd0; d4_in_valid = 4'hF; d4_in_data = 64'h0; d4_out_ready = 1'b1;
    d5_mode      = 1'b0; d5_sel = 3'd0; d5_in_valid = 5'h1F; d5_in_data = 40'h0; d5_out_ready = 1'b1;
    d2_mode      = 1'b0; d2_sel = 1'b0; d2_in_valid = 2'b11; d2_in_data = 2'b00; d2_out_ready = 1'b1;

    #2;
    check("rst_valid", 32'(d4_out_valid), 32'h0);
    check("rst_data", 32'(d4_out_data), 32'h0);
    check("rst_chan", 32'(d4_out_chan), 32'h0);
    check("rst_ready4", 32'(d4_in_ready), 32'h0);
    check("rst_ready5", 32'(d5_in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // legacy 2:1 truth table
    for (int i = 0; i < 8; i++) begin
      d2_sel     = tbl[i].sel;
      d2_in_data = {tbl[i].b, tbl[i].a};
      #1;
      check("leg_ready", 32'(d2_in_ready), tbl[i].sel ? 32'h2 : 32'h1);
      @(negedge clk);
      check("leg_data", 32'(d2_out_data), 32'(tbl[i].exp));
      check("leg_chan", 32'(d2_out_chan), 32'(tbl[i].sel));
      check("leg_valid", 32'(d2_out_valid), 32'h1);
    end

    // fixed select on channel 2
    d4_mode    = 1'b0;
    d4_sel     = 2'd2;
    d4_in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    #1;
    check("fix_ready", 32'(d4_in_ready), 32'h4);
    @(negedge clk);
    check("fix_data", 32'(d4_out_data), 32'hBEEF);
    check("fix_chan", 32'(d4_out_chan), 32'h2);
    check("fix_valid", 32'(d4_out_valid), 32'h1);
    check("fix_ready2", 32'(d4_in_ready), 32'h4);
    d4_in_valid = 4'b1011;
    #1;
    check("fix_ready_noval", 32'(d4_in_ready), 32'h4);
    @(negedge clk);
    check("fix_bubble_valid", 32'(d4_out_valid), 32'h0);
    check("fix_bubble_data", 32'(d4_out_data), 32'hBEEF);

    // select beyond the channel count grants nothing
    d5_sel     = 3'd4;
    d5_in_data = {8'hA4, 8'h33, 8'h22, 8'h11, 8'h00};
    #1;
    check("sel4_ready", 32'(d5_in_ready), 32'h10);
    @(negedge clk);
    check("sel4_data", 32'(d5_out_data), 32'hA4);
    check("sel4_chan", 32'(d5_out_chan), 32'h4);
    d5_sel = 3'd5;
    #1;
    check("sel5_ready", 32'(d5_in_ready), 32'h0);
    @(negedge clk);
    check("sel5_valid", 32'(d5_out_valid), 32'h0);
    check("sel5_data", 32'(d5_out_data), 32'hA4);
    check("sel5_chan", 32'(d5_out_chan), 32'h4);
    d5_sel = 3'd7;
    #1;
    check("sel7_ready", 32'(d5_in_ready), 32'h0);

    // round-robin, all valid
    d4_mode     = 1'b1;
    d4_in_valid = 4'hF;
    d4_in_data  = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_chan", 32'(d4_out_chan), 32'(i % 4));
      check("rr_data", 32'(d4_out_data), 32'(i % 4));
      check("rr_valid", 32'(d4_out_valid), 32'h1);
    end

    // sparse valid
    d4_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sparse_chan", 32'(d4_out_chan), (i % 2 == 1) ? 32'h3 : 32'h1);
      check("sparse_valid", 32'(d4_out_valid), 32'h1);
    end
    d4_in_valid = 4'b0000;
    @(negedge clk);
    check("drain_valid", 32'(d4_out_valid), 32'h0);
    check("drain_chan", 32'(d4_out_chan), 32'h3);

    // backpressure while holding channel 1
    d4_in_valid = 4'hF;
    @(negedge clk);
    check("bp_chan0", 32'(d4_out_chan), 32'h0);
    @(negedge clk);
    check("bp_chan1", 32'(d4_out_chan), 32'h1);
    d4_out_ready = 1'b0;
    #1;
    check("bp_ready", 32'(d4_in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_chan", 32'(d4_out_chan), 32'h1);
      check("bp_hold_data", 32'(d4_out_data), 32'h1);
      check("bp_hold_valid", 32'(d4_out_valid), 32'h1);
      check("bp_hold_ready", 32'(d4_in_ready), 32'h0);
    end
    d4_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(d4_in_ready), 32'h4);
    @(negedge clk);
    check("bp_release_chan", 32'(d4_out_chan), 32'h2);
    check("bp_release_data", 32'(d4_out_data), 32'h2);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(d4_out_valid), 32'h0);
    check("mid_rst_data", 32'(d4_out_data), 32'h0);
    check("mid_rst_chan", 32'(d4_out_chan), 32'h0);
    check("mid_rst_ready", 32'(d4_in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_chan", 32'(d4_out_chan), 32'h0);
    check("post_rst_valid", 32'(d4_out_valid), 32'h1);

    // randomized run against the model
    d4_in_valid = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_val  = 1'b0;
    m_data = 16'h0;
    m_chan = 0;
    for (int i = 0; i < 400; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
